// File: rtl/com_bus_arbiter_rr.sv
// Round-robin common-bus arbiter for the MESI cache system: a proc domain with turnaround and
// hold watchdog, plus a snoop domain (caches before memory) that is live only under a proc grant.
module com_bus_arbiter_rr #(
  parameter int NUM_PROC  = 8,
  parameter int NUM_SNOOP = 4,
  parameter int MAX_HOLD  = 64,
  localparam int PW = (NUM_PROC  > 1) ? $clog2(NUM_PROC)  : 1,
  localparam int SW = (NUM_SNOOP > 1) ? $clog2(NUM_SNOOP) : 1,
  localparam int CW = $clog2(MAX_HOLD)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PROC-1:0]  Com_Bus_Req_proc,
  input  logic [NUM_SNOOP-1:0] Com_Bus_Req_snoop,
  input  logic                 Mem_snoop_req,
  output logic [NUM_PROC-1:0]  Com_Bus_Gnt_proc,
  output logic [NUM_SNOOP-1:0] Com_Bus_Gnt_snoop,
  output logic                 Mem_snoop_gnt,
  output logic [PW-1:0]        proc_owner,
  output logic                 bus_busy,
  output logic                 hold_timeout
);

  typedef enum logic [1:0] {P_IDLE, P_GNT, P_TURN} p_state_t;
  typedef enum logic       {S_IDLE, S_GNT}         s_state_t;

  p_state_t             p_state_q, p_state_d;
  s_state_t             s_state_q, s_state_d;
  logic [NUM_PROC-1:0]  gnt_proc_q, gnt_proc_d;
  logic [NUM_PROC-1:0]  mask_q, mask_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [PW-1:0]        pptr_q, pptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 tmo_q, tmo_d;
  logic [NUM_SNOOP-1:0] gnt_snoop_q, gnt_snoop_d;
  logic [SW-1:0]        sowner_q, sowner_d;
  logic [SW-1:0]        sptr_q, sptr_d;
  logic                 mem_gnt_q, mem_gnt_d;
  logic                 s_mem_q, s_mem_d;

  logic                 p_release, p_hold;
  logic [NUM_PROC-1:0]  elig_p;
  logic [NUM_SNOOP-1:0] elig_s, excl_s;
  logic [4:0]           pick_p, pick_s;

  // First set bit of req at or after ptr, wrapping at n; lowest offset wins.
  function automatic logic [4:0] rr_pick(input logic [15:0] req, input logic [4:0] n,
                                         input logic [4:0] ptr);
    logic [4:0] idx;
    rr_pick = '0;
    for (int k = 15; k >= 0; k--) begin
      idx = ptr + 5'(k);
      if (idx >= n) idx = idx - n;
      if ((5'(k) < n) && req[idx[3:0]]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    p_state_d  = p_state_q;
    gnt_proc_d = gnt_proc_q;
    owner_d    = owner_q;
    pptr_d     = pptr_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    tmo_d      = 1'b0;
    mask_d     = mask_q & Com_Bus_Req_proc;
    p_release  = 1'b0;
    p_hold     = 1'b0;
    elig_p     = Com_Bus_Req_proc & ~mask_q;
    pick_p     = rr_pick(16'(elig_p), 5'(NUM_PROC), 5'(pptr_q));

    case (p_state_q)
      P_GNT: begin
        if (!Com_Bus_Req_proc[owner_q]) begin
          p_release = 1'b1;
        end else if (cnt_q == CW'(MAX_HOLD - 1)) begin
          p_release       = 1'b1;
          tmo_d           = 1'b1;
          mask_d[owner_q] = 1'b1;
        end else begin
          p_hold = 1'b1;
          cnt_d  = cnt_q + CW'(1);
        end
        if (p_release) begin
          gnt_proc_d = '0;
          busy_d     = 1'b0;
          pptr_d     = (owner_q == PW'(NUM_PROC - 1)) ? '0 : owner_q + PW'(1);
          p_state_d  = P_TURN;
        end
      end
      // The P_TURN cycle itself is the bus gap, so its closing edge may arbitrate.
      default: begin
        if (|elig_p) begin
          gnt_proc_d = NUM_PROC'(1) << pick_p;
          owner_d    = pick_p[PW-1:0];
          busy_d     = 1'b1;
          cnt_d      = '0;
          p_state_d  = P_GNT;
        end else begin
          gnt_proc_d = '0;
          busy_d     = 1'b0;
          p_state_d  = P_IDLE;
        end
      end
    endcase

    s_state_d   = s_state_q;
    gnt_snoop_d = gnt_snoop_q;
    sowner_d    = sowner_q;
    sptr_d      = sptr_q;
    mem_gnt_d   = mem_gnt_q;
    s_mem_d     = s_mem_q;
    excl_s      = '0;
    for (int i = 0; i < NUM_SNOOP; i++) begin
      if ((i < NUM_PROC) && (owner_q == PW'(i))) excl_s[i] = 1'b1;
    end
    elig_s = Com_Bus_Req_snoop & ~excl_s;
    pick_s = rr_pick(16'(elig_s), 5'(NUM_SNOOP), 5'(sptr_q));

    if (!p_hold) begin
      gnt_snoop_d = '0;
      mem_gnt_d   = 1'b0;
      s_state_d   = S_IDLE;
    end else begin
      case (s_state_q)
        S_IDLE: begin
          if (|elig_s) begin
            gnt_snoop_d = NUM_SNOOP'(1) << pick_s;
            sowner_d    = pick_s[SW-1:0];
            s_mem_d     = 1'b0;
            s_state_d   = S_GNT;
          end else if (Mem_snoop_req) begin
            mem_gnt_d = 1'b1;
            s_mem_d   = 1'b1;
            s_state_d = S_GNT;
          end
        end
        default: begin
          if (s_mem_q) begin
            if (!Mem_snoop_req) begin
              mem_gnt_d = 1'b0;
              s_state_d = S_IDLE;
            end
          end else if (!Com_Bus_Req_snoop[sowner_q]) begin
            gnt_snoop_d = '0;
            sptr_d      = (sowner_q == SW'(NUM_SNOOP - 1)) ? '0 : sowner_q + SW'(1);
            s_state_d   = S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_state_q   <= P_IDLE;
      s_state_q   <= S_IDLE;
      gnt_proc_q  <= '0;
      mask_q      <= '0;
      owner_q     <= '0;
      pptr_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      tmo_q       <= 1'b0;
      gnt_snoop_q <= '0;
      sowner_q    <= '0;
      sptr_q      <= '0;
      mem_gnt_q   <= 1'b0;
      s_mem_q     <= 1'b0;
    end else begin
      p_state_q   <= p_state_d;
      s_state_q   <= s_state_d;
      gnt_proc_q  <= gnt_proc_d;
      mask_q      <= mask_d;
      owner_q     <= owner_d;
      pptr_q      <= pptr_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      tmo_q       <= tmo_d;
      gnt_snoop_q <= gnt_snoop_d;
      sowner_q    <= sowner_d;
      sptr_q      <= sptr_d;
      mem_gnt_q   <= mem_gnt_d;
      s_mem_q     <= s_mem_d;
    end
  end

  assign Com_Bus_Gnt_proc  = gnt_proc_q;
  assign Com_Bus_Gnt_snoop = gnt_snoop_q;
  assign Mem_snoop_gnt     = mem_gnt_q;
  assign proc_owner        = owner_q;
  assign bus_busy          = busy_q;
  assign hold_timeout      = tmo_q;

endmodule

// File: tb/tb_com_bus_arbiter_rr.sv
// Bench for com_bus_arbiter_rr: directed test-plan steps, then random traffic against an
// index-based reference model of the arbitration rules.
module tb_com_bus_arbiter_rr;
  localparam int NP  = 8;
  localparam int NS  = 4;
  localparam int MH  = 16;
  localparam int MEM = 99;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] req_proc;
  logic [NS-1:0] req_snoop;
  logic          mem_req;
  logic [NP-1:0] gnt_proc;
  logic [NS-1:0] gnt_snoop;
  logic          mem_gnt;
  logic [2:0]    proc_owner;
  logic          busy;
  logic          tmo;

  int n_cmp = 0;
  int n_bad = 0;

  com_bus_arbiter_rr #(.NUM_PROC(NP), .NUM_SNOOP(NS), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst),
    .Com_Bus_Req_proc(req_proc), .Com_Bus_Req_snoop(req_snoop), .Mem_snoop_req(mem_req),
    .Com_Bus_Gnt_proc(gnt_proc), .Com_Bus_Gnt_snoop(gnt_snoop), .Mem_snoop_gnt(mem_gnt),
    .proc_owner(proc_owner), .bus_busy(busy), .hold_timeout(tmo)
  );

  always #5 clk = ~clk;

  // Reference model: owner index (-1 none), cycles the grant has been visible, pointers,
  // per-requester block flags after a timeout, snoop owner (-1 none, MEM for memory).
  int m_owner, m_held, m_ptr, m_sown, m_sptr;
  bit m_tmo;
  bit m_blk [NP];

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_ptr = 0; m_sown = -1; m_sptr = 0; m_tmo = 0;
    for (int i = 0; i < NP; i++) m_blk[i] = 0;
  endtask

  task automatic model_step();
    int n_owner, n_held, n_ptr, n_sown, n_sptr, c;
    bit n_tmo, stays, found;
    bit n_blk [NP];
    n_owner = m_owner; n_held = m_held; n_ptr = m_ptr; n_sown = m_sown; n_sptr = m_sptr;
    n_tmo = 0; stays = 0; found = 0;
    for (int i = 0; i < NP; i++) n_blk[i] = m_blk[i] && req_proc[i];
    if (m_owner < 0) begin
      for (int k = 0; k < NP; k++) begin
        c = (m_ptr + k) % NP;
        if (!found && req_proc[c] && !m_blk[c]) begin
          found = 1; n_owner = c; n_held = 1;
        end
      end
    end else if (!req_proc[m_owner]) begin
      n_owner = -1; n_ptr = (m_owner + 1) % NP;
    end else if (m_held == MH) begin
      n_owner = -1; n_ptr = (m_owner + 1) % NP; n_tmo = 1; n_blk[m_owner] = 1;
    end else begin
      n_held = m_held + 1; stays = 1;
    end
    found = 0;
    if (!stays) begin
      n_sown = -1;
    end else if (m_sown == -1) begin
      for (int k = 0; k < NS; k++) begin
        c = (m_sptr + k) % NS;
        if (!found && req_snoop[c] && c != m_owner) begin
          found = 1; n_sown = c;
        end
      end
      if (!found && mem_req) n_sown = MEM;
    end else if (m_sown == MEM) begin
      if (!mem_req) n_sown = -1;
    end else if (!req_snoop[m_sown]) begin
      n_sown = -1; n_sptr = (m_sown + 1) % NS;
    end
    m_owner = n_owner; m_held = n_held; m_ptr = n_ptr; m_sown = n_sown; m_sptr = n_sptr;
    m_tmo = n_tmo;
    for (int i = 0; i < NP; i++) m_blk[i] = n_blk[i];
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] e_gp, e_gs;
    e_gp = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    e_gs = (m_sown >= 0 && m_sown != MEM) ? (32'd1 << m_sown) : 32'd0;
    chk("gnt_proc", 32'(gnt_proc), e_gp);
    chk("bus_busy", 32'(busy), 32'(m_owner >= 0));
    if (m_owner >= 0) chk("proc_owner", 32'(proc_owner), 32'(m_owner));
    chk("gnt_snoop", 32'(gnt_snoop), e_gs);
    chk("mem_gnt", 32'(mem_gnt), 32'(m_sown == MEM));
    chk("hold_timeout", 32'(tmo), 32'(m_tmo));
    chk("inv_proc_onehot", 32'($countones(gnt_proc) <= 1), 32'd1);
    chk("inv_snoop_onehot", 32'(($countones(gnt_snoop) + 32'(mem_gnt)) <= 1), 32'd1);
    chk("inv_snoop_needs_busy", 32'((|gnt_snoop || mem_gnt) && !busy), 32'd0);
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_proc = '0; req_snoop = '0; mem_req = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gp"}, 32'(gnt_proc), 32'd0);
    chk({tag, "_gs"}, 32'(gnt_snoop), 32'd0);
    chk({tag, "_mem"}, 32'(mem_gnt), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_tmo"}, 32'(tmo), 32'd0);
    chk({tag, "_owner"}, 32'(proc_owner), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_proc = '0; req_snoop = '0; mem_req = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    check_all();
    rst = 1'b0;

    // Single request, then pointer left at 3
    req_proc = 8'h04;
    step();
    chk("tp1_gnt", 32'(gnt_proc), 32'h04);
    chk("tp1_owner", 32'(proc_owner), 32'd2);
    chk("tp1_busy", 32'(busy), 32'd1);
    repeat (4) step();
    chk("tp1_held", 32'(gnt_proc), 32'h04);
    req_proc = 8'h00;
    step();
    chk("tp1_drop", 32'(gnt_proc), 32'h00);
    req_proc = 8'h09;
    step();
    chk("tp1_ptr3", 32'(gnt_proc), 32'h08);
    req_proc = 8'h00;
    repeat (2) step();

    // Round robin over all eight with a one-cycle gap between owners
    do_reset();
    req_proc = 8'hFF;
    step();
    for (int k = 0; k < 9; k++) begin
      chk("rr_owner", 32'(proc_owner), 32'(k % NP));
      chk("rr_gnt", 32'(gnt_proc), 32'd1 << (k % NP));
      repeat (2) step();
      req_proc = 8'hFF & ~(8'h01 << (k % NP));
      step();
      chk("rr_gap", 32'(gnt_proc), 32'd0);
      req_proc = 8'hFF;
      step();
    end
    req_proc = 8'h00;
    repeat (2) step();

    // Snoop priority: caches round robin, memory last
    do_reset();
    req_proc = 8'h02;
    step();
    req_snoop = 4'b0101; mem_req = 1'b1;
    step();
    chk("tp3_first", 32'(gnt_snoop), 32'b0001);
    chk("tp3_mem_wait", 32'(mem_gnt), 32'd0);
    repeat (2) step();
    req_snoop = 4'b0100;
    step();
    chk("tp3_release", 32'(gnt_snoop), 32'b0000);
    step();
    chk("tp3_second", 32'(gnt_snoop), 32'b0100);
    chk("tp3_mem_wait2", 32'(mem_gnt), 32'd0);
    req_snoop = 4'b0000;
    step();
    step();
    chk("tp3_mem", 32'(mem_gnt), 32'd1);
    req_proc = 8'h00; mem_req = 1'b0;
    repeat (2) step();

    // Own-snoop exclusion and proc release killing the memory grant
    do_reset();
    req_proc = 8'h01;
    step();
    req_snoop = 4'b0001;
    repeat (2) step();
    chk("excl_own", 32'(gnt_snoop), 32'd0);
    req_snoop = 4'b0011;
    step();
    chk("excl_other", 32'(gnt_snoop), 32'b0010);
    req_snoop = 4'b0000; mem_req = 1'b1;
    repeat (2) step();
    chk("kill_pre_mem", 32'(mem_gnt), 32'd1);
    req_proc = 8'h00;
    step();
    chk("kill_gp", 32'(gnt_proc), 32'd0);
    chk("kill_mem", 32'(mem_gnt), 32'd0);
    mem_req = 1'b0;
    step();

    // Hold timeout: proc 3 holds past MAX_HOLD, proc 5 waiting
    do_reset();
    req_proc = 8'h28;
    step();
    for (int i = 0; i < MH; i++) begin
      chk("tmo_held", 32'(gnt_proc), 32'h08);
      if (i < MH - 1) step();
    end
    step();
    chk("tmo_revoke", 32'(gnt_proc), 32'd0);
    chk("tmo_pulse", 32'(tmo), 32'd1);
    step();
    chk("tmo_next", 32'(gnt_proc), 32'h20);
    chk("tmo_pulse_end", 32'(tmo), 32'd0);
    repeat (2) step();
    req_proc = 8'h08;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("tmo_masked", 32'(gnt_proc), 32'd0);
    end
    req_proc = 8'h00;
    step();
    req_proc = 8'h08;
    step();
    chk("tmo_regrant", 32'(gnt_proc), 32'h08);
    req_proc = 8'h00;
    repeat (2) step();

    // Asynchronous reset between edges while proc 5 and snoop 2 are granted
    do_reset();
    req_proc = 8'h02;
    step();
    req_proc = 8'h00;
    repeat (2) step();
    req_proc = 8'h20;
    step();
    req_snoop = 4'b0100;
    step();
    chk("ar_pre_gp", 32'(gnt_proc), 32'h20);
    chk("ar_pre_gs", 32'(gnt_snoop), 32'b0100);
    #2 rst = 1'b1;
    #1 chk_all_zero("ar_async");
    #1 rst = 1'b0;
    step();
    chk("ar_regrant", 32'(gnt_proc), 32'h20);
    chk("ar_owner", 32'(proc_owner), 32'd5);
    req_proc = 8'h00; req_snoop = 4'b0000;
    repeat (2) step();

    // Random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NP; i++) if ($urandom_range(0, 11) == 0) req_proc[i] = ~req_proc[i];
      for (int i = 0; i < NS; i++) if ($urandom_range(0, 3) == 0) req_snoop[i] = ~req_snoop[i];
      if ($urandom_range(0, 4) == 0) mem_req = ~mem_req;
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        #1 chk_all_zero("rnd_async");
        #1 rst = 1'b0;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
